cram_responder: RTL



---
 rtl/cram_responder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/cram_responder.sv
// cram_responder: asynchronous cellular-RAM device emulator serving reads and writes from internal RAM
module cram_responder #(
    parameter int ADDR_W       = 10,
    parameter int READ_LATENCY = 3,
    parameter int WRITE_MIN    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [22:0] MemAdr,
    input  logic        RamAdv,
    input  logic        RamClk,
    input  logic        RamCS,
    input  logic        MemOE,
    input  logic        MemWR,
    input  logic        RamLB,
    input  logic        RamUB,
    input  logic [15:0] mem_db_in,
    output logic [15:0] mem_db_out,
    output logic        mem_db_oe,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic        proto_err,
    output logic        timing_err
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DRIVE, WR_ACTIVE} state_t;
    state_t      state, state_n;
    logic [22:0] s_adr, lat_adr, lat_adr_n;
    logic        s_adv, s_clk, s_cs, s_oe, s_wr, s_lb, s_ub;
    logic [15:0] s_din, w_din, w_din_n;
    logic        w_lb, w_ub, w_lb_n, w_ub_n;
    logic [2:0]  cnt, cnt_n;
    logic        drive, drive_n;
    logic [15:0] dout_n, rd_count_n, wr_count_n;
    logic        proto_n, timing_n, wr_commit, lat_ok;
    logic [15:0] rd_word, rd_masked;
    logic [15:0] mem [0:(1<<ADDR_W)-1];

    // register every bus input once; strobes idle high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_adr <= '0;
            s_din <= '0;
            {s_adv, s_clk, s_cs, s_oe, s_wr, s_lb, s_ub} <= 7'b1011111;
        end else begin
            s_adr <= MemAdr;
            s_din <= mem_db_in;
            {s_adv, s_clk, s_cs, s_oe, s_wr, s_lb, s_ub} <= {RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB};
        end
    end

    // read data for the latched address, with disabled lanes forced to zero
    always_comb begin
        lat_ok    = lat_adr[22:ADDR_W] == '0;
        rd_word   = lat_ok ? mem[lat_adr[ADDR_W-1:0]] : 16'h0000;
        rd_masked = {s_ub ? 8'h00 : rd_word[15:8], s_lb ? 8'h00 : rd_word[7:0]};
    end

    // next-state and datapath decisions from the sampled strobes
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        lat_adr_n  = lat_adr;
        w_din_n    = w_din;
        w_lb_n     = w_lb;
        w_ub_n     = w_ub;
        drive_n    = 1'b0;
        dout_n     = mem_db_out;
        rd_count_n = rd_count;
        wr_count_n = wr_count;
        proto_n    = proto_err | (!s_cs && (s_clk || (!s_oe && !s_wr)));
        timing_n   = timing_err;
        wr_commit  = 1'b0;
        case (state)
            IDLE: begin
                if (!s_cs && !s_wr) begin
                    state_n = WR_ACTIVE;
                    cnt_n   = 3'd1;
                    w_din_n = s_din;
                    w_lb_n  = s_lb;
                    w_ub_n  = s_ub;
                    if (!s_adv) lat_adr_n = s_adr;
                end else if (!s_cs && !s_oe) begin
                    state_n = RD_WAIT;
                    cnt_n   = 3'd1;
                    if (!s_adv) lat_adr_n = s_adr;
                end
            end
            RD_WAIT: begin
                if (s_cs || s_oe || !s_wr) state_n = IDLE;
                else if (cnt == 3'(READ_LATENCY)) begin
                    state_n = RD_DRIVE;
                    drive_n = 1'b1;
                    dout_n  = rd_masked;
                end else cnt_n = cnt + 3'd1;
            end
            RD_DRIVE: begin
                if (s_cs || s_oe || !s_wr) begin
                    state_n    = IDLE;
                    rd_count_n = rd_count + 16'd1;
                end else if (!s_adv && s_adr != lat_adr) begin
                    state_n    = RD_WAIT;
                    cnt_n      = 3'd1;
                    lat_adr_n  = s_adr;
                    rd_count_n = rd_count + 16'd1;
                end else begin
                    drive_n = 1'b1;
                    dout_n  = rd_masked;
                end
            end
            WR_ACTIVE: begin
                if (s_cs || s_wr) begin
                    state_n = IDLE;
                    if (cnt >= 3'(WRITE_MIN)) begin
                        wr_commit  = lat_ok;
                        wr_count_n = wr_count + 16'(lat_ok);
                    end else timing_n = 1'b1;
                end else begin
                    cnt_n   = cnt == 3'd7 ? 3'd7 : cnt + 3'd1;
                    w_din_n = s_din;
                    w_lb_n  = s_lb;
                    w_ub_n  = s_ub;
                    if (!s_adv) lat_adr_n = s_adr;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // state, latched access and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_adr    <= '0;
            w_din      <= '0;
            w_lb       <= 1'b1;
            w_ub       <= 1'b1;
            drive      <= 1'b0;
            mem_db_out <= '0;
            rd_count   <= '0;
            wr_count   <= '0;
            proto_err  <= 1'b0;
            timing_err <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            lat_adr    <= lat_adr_n;
            w_din      <= w_din_n;
            w_lb       <= w_lb_n;
            w_ub       <= w_ub_n;
            drive      <= drive_n;
            mem_db_out <= dout_n;
            rd_count   <= rd_count_n;
            wr_count   <= wr_count_n;
            proto_err  <= proto_n;
            timing_err <= timing_n;
        end
    end

    // byte-lane write into the array on strobe release; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_commit && !w_lb) mem[lat_adr[ADDR_W-1:0]][7:0] <= w_din[7:0];
        if (wr_commit && !w_ub) mem[lat_adr[ADDR_W-1:0]][15:8] <= w_din[15:8];
    end

    // a sampled write strobe immediately silences the driver so both sides never drive together
    assign mem_db_oe = drive & s_wr;
endmodule
